// File: rtl/reaction_timer_pkg.sv
// Shared types and widths for the reaction-timer controller.
package reaction_timer_pkg;

  localparam int unsigned RESULT_W = 14;
  localparam int unsigned DELAY_W  = 16;
  localparam int unsigned RAND_W   = 8;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_CAPTURE = 3'd2,
    S_WAIT    = 3'd3,
    S_GO      = 3'd4,
    S_DONE    = 3'd5,
    S_FAULT   = 3'd6,
    S_TMO     = 3'd7
  } state_t;

  // A round is in progress from the LFSR request until the player responds.
  function automatic logic is_busy(input state_t s);
    return (s == S_LOAD) || (s == S_CAPTURE) || (s == S_WAIT) || (s == S_GO);
  endfunction

  // Terminal states wait for the next start pulse.
  function automatic logic is_idle_like(input state_t s);
    return (s == S_IDLE) || (s == S_DONE) || (s == S_FAULT) || (s == S_TMO);
  endfunction

endpackage

// File: rtl/reaction_timer_controller_ms_tick_gen.sv
// Millisecond tick prescaler: tick is high while the count sits at TICK_CYCLES-1.
module ms_tick_gen #(
  parameter int unsigned TICK_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned PRE_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_CYCLES - 1);

  logic [PRE_W-1:0] prescaler;

  // Count 0..TICK_CYCLES-1 and wrap; clr restarts the millisecond boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler <= '0;
    end else if (clr || (prescaler == PRE_MAX)) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + PRE_W'(1);
    end
  end

  assign tick = (prescaler == PRE_MAX);

endmodule

// File: rtl/reaction_timer_controller.sv
// Round sequencer: random wait, go LED, reaction measurement, false start and timeout.
module reaction_timer_controller
  import reaction_timer_pkg::*;
#(
  parameter int unsigned TICK_CYCLES  = 50000,
  parameter int unsigned MIN_DELAY_MS = 1000,
  parameter int unsigned DELAY_SCALE  = 8,
  parameter int unsigned MAX_REACT_MS = 9999
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                button,
  input  logic [RAND_W-1:0]   rand_in,
  output logic                rand_next,
  output logic                led_go,
  output logic                busy,
  output logic [RESULT_W-1:0] result_ms,
  output logic                result_valid,
  output logic                false_start,
  output logic                timeout
);

  localparam int unsigned SCALE_SHIFT = (DELAY_SCALE > 1) ? $clog2(DELAY_SCALE) : 0;
  localparam logic [DELAY_W-1:0]  MIN_DELAY = DELAY_W'(MIN_DELAY_MS);
  localparam logic [RESULT_W-1:0] MAX_REACT = RESULT_W'(MAX_REACT_MS);

  state_t state;
  state_t next_state;

  logic                tick;
  logic [DELAY_W-1:0]  delay_ms;
  logic [RESULT_W-1:0] ms_count;

  logic wait_done_c;
  logic go_limit_c;
  logic clr_c;
  logic cnt_clr_c;
  logic cnt_inc_c;
  logic load_delay_c;
  logic capture_result_c;
  logic enter_fault_c;
  logic enter_tmo_c;

  ms_tick_gen #(
    .TICK_CYCLES (TICK_CYCLES)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr_c),
    .tick (tick)
  );

  assign wait_done_c = tick && (DELAY_W'(ms_count) == (delay_ms - DELAY_W'(1)));
  assign go_limit_c  = tick && (ms_count == MAX_REACT);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and datapath control; the button wins over any same-cycle tick event.
  always_comb begin
    next_state       = state;
    clr_c            = 1'b0;
    cnt_clr_c        = 1'b0;
    cnt_inc_c        = 1'b0;
    load_delay_c     = 1'b0;
    capture_result_c = 1'b0;
    enter_fault_c    = 1'b0;
    enter_tmo_c      = 1'b0;
    unique case (state)
      S_IDLE, S_DONE, S_FAULT, S_TMO: begin
        if (start) begin
          next_state = S_LOAD;
        end
      end
      S_LOAD: begin
        next_state = S_CAPTURE;
      end
      S_CAPTURE: begin
        next_state   = S_WAIT;
        load_delay_c = 1'b1;
        clr_c        = 1'b1;
        cnt_clr_c    = 1'b1;
      end
      S_WAIT: begin
        if (button) begin
          next_state    = S_FAULT;
          enter_fault_c = 1'b1;
        end else if (wait_done_c) begin
          next_state = S_GO;
          clr_c      = 1'b1;
          cnt_clr_c  = 1'b1;
        end else if (tick) begin
          cnt_inc_c = 1'b1;
        end
      end
      S_GO: begin
        if (button) begin
          next_state       = S_DONE;
          capture_result_c = 1'b1;
        end else if (go_limit_c) begin
          next_state  = S_TMO;
          enter_tmo_c = 1'b1;
        end else if (tick) begin
          cnt_inc_c = 1'b1;
        end
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // Random delay, millisecond counter and measured result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      delay_ms  <= '0;
      ms_count  <= '0;
      result_ms <= '0;
    end else begin
      if (load_delay_c) begin
        delay_ms <= MIN_DELAY + (DELAY_W'(rand_in) << SCALE_SHIFT);
      end
      if (cnt_clr_c) begin
        ms_count <= '0;
      end else if (cnt_inc_c) begin
        ms_count <= ms_count + RESULT_W'(1);
      end
      if (capture_result_c) begin
        result_ms <= ms_count;
      end else if (enter_fault_c) begin
        result_ms <= '0;
      end else if (enter_tmo_c) begin
        result_ms <= MAX_REACT;
      end
    end
  end

  // Moore outputs registered from the next state so they track the state register exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rand_next    <= 1'b0;
      led_go       <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      false_start  <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      rand_next    <= (next_state == S_LOAD);
      led_go       <= (next_state == S_GO);
      busy         <= is_busy(next_state);
      result_valid <= (next_state == S_DONE);
      false_start  <= (next_state == S_FAULT);
      timeout      <= (next_state == S_TMO);
    end
  end

endmodule

// File: tb/tb_reaction_timer_controller.sv
// Self-checking bench for reaction_timer_controller with a round-level reference model.
module tb_reaction_timer_controller;

  localparam int unsigned TC     = 4;
  localparam int unsigned MIN_MS = 2;
  localparam int unsigned SCALE  = 1;
  localparam int unsigned MAX_MS = 5;

  localparam int PH_IDLE  = 0;
  localparam int PH_WAIT  = 1;
  localparam int PH_GO    = 2;
  localparam int PH_DONE  = 3;
  localparam int PH_FAULT = 4;
  localparam int PH_TMO   = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        button = 1'b0;
  logic [7:0]  rand_in = 8'h00;
  logic        rand_next;
  logic        led_go;
  logic        busy;
  logic [13:0] result_ms;
  logic        result_valid;
  logic        false_start;
  logic        timeout;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  reaction_timer_controller #(
    .TICK_CYCLES  (TC),
    .MIN_DELAY_MS (MIN_MS),
    .DELAY_SCALE  (SCALE),
    .MAX_REACT_MS (MAX_MS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .button       (button),
    .rand_in      (rand_in),
    .rand_next    (rand_next),
    .led_go       (led_go),
    .busy         (busy),
    .result_ms    (result_ms),
    .result_valid (result_valid),
    .false_start  (false_start),
    .timeout      (timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Expected {led_go, busy, result_valid, false_start, timeout} for a game phase.
  function automatic logic [4:0] phase_vec(input int ph);
    case (ph)
      PH_WAIT:  return 5'b01000;
      PH_GO:    return 5'b11000;
      PH_DONE:  return 5'b00100;
      PH_FAULT: return 5'b00010;
      PH_TMO:   return 5'b00001;
      default:  return 5'b00000;
    endcase
  endfunction

  function automatic logic [4:0] obs_vec();
    return {led_go, busy, result_valid, false_start, timeout};
  endfunction

  // One round. t counts cycles from the first WAIT cycle. press_w: WAIT cycle of a press,
  // press_g: GO cycle of a press, start_at: cycle of a stray start, rst_at: cycle of an async reset
  // (-1 disables each).
  task automatic run_round(input int r, input int press_w, input int press_g,
                           input int start_at, input int rst_at);
    int d_cyc, lim, end_t, kind, res, ph, n, stop;
    d_cyc = int'((MIN_MS + r * SCALE) * TC);
    lim   = int'((MAX_MS + 1) * TC) - 1;
    if (press_w >= 0 && press_w < d_cyc) begin
      kind = PH_FAULT; res = 0; end_t = press_w + 3;
    end else if (press_g >= 0 && press_g <= lim) begin
      kind = PH_DONE; res = press_g / int'(TC); end_t = d_cyc + press_g + 3;
    end else begin
      kind = PH_TMO; res = int'(MAX_MS); end_t = d_cyc + lim + 3;
    end

    rand_in = ~8'(r);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("load_rand_next", rand_next, 1);
    chk("load_flags", obs_vec(), 5'b01000);
    @(negedge clk);
    rand_in = 8'(r);
    chk("capture_rand_next", rand_next, 0);
    chk("capture_busy", busy, 1);

    for (int t = 0; t <= end_t; t++) begin
      @(negedge clk);
      if (kind == PH_FAULT) begin
        ph = (t <= press_w) ? PH_WAIT : PH_FAULT;
      end else if (t < d_cyc) begin
        ph = PH_WAIT;
      end else begin
        n    = t - d_cyc;
        stop = (kind == PH_DONE) ? press_g : lim;
        ph   = (n <= stop) ? PH_GO : kind;
      end
      chk($sformatf("phase t=%0d", t), obs_vec(), phase_vec(ph));
      chk($sformatf("rand_next t=%0d", t), rand_next, 0);
      if (t == rst_at) begin
        #2 rst = 1'b1;
        #1;
        chk("async_rst_flags", {rand_next, obs_vec()}, 6'b0);
        chk("async_rst_result", result_ms, 0);
        @(negedge clk);
        rst = 1'b0;
        button = 1'b0;
        start = 1'b0;
        chk("post_rst_flags", {rand_next, obs_vec()}, 6'b0);
        return;
      end
      button = (t == press_w) || (press_g >= 0 && t == d_cyc + press_g);
      start  = (t == start_at);
    end
    button = 1'b0;
    start  = 1'b0;
    chk("result_ms", result_ms, res);
  endtask

  initial begin
    int r, mode, d, pw, pg, sa;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_flags", {rand_next, obs_vec()}, 6'b0);
    chk("reset_result", result_ms, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_flags", {rand_next, obs_vec()}, 6'b0);

    // Normal round: delay 5 ms = 20 cycles, press 13 cycles into GO -> 3 ms.
    run_round(3, -1, 13, -1, -1);
    // False start 6 cycles into WAIT.
    run_round(3, 6, -1, -1, -1);
    // No press: timeout after 24 GO cycles.
    run_round(1, -1, -1, -1, -1);
    // Press in the last GO cycle before timeout still scores.
    run_round(0, -1, 23, -1, -1);
    // Stray start during WAIT, then during GO.
    run_round(2, -1, 10, 7, -1);
    run_round(2, -1, 10, 20, -1);
    // Press coincides with delay expiry: false start.
    run_round(0, 7, -1, -1, -1);
    // Press in the first GO cycle.
    run_round(1, -1, 0, -1, -1);
    // Async reset mid-GO, then a clean round.
    run_round(1, -1, -1, -1, 17);
    run_round(4, -1, 9, -1, -1);

    for (int i = 0; i < 8; i++) begin
      r    = int'($urandom_range(0, 7));
      mode = int'($urandom_range(0, 2));
      d    = int'((MIN_MS + r * SCALE) * TC);
      pw = -1; pg = -1; sa = -1;
      if (mode == 0) begin
        pw = int'($urandom_range(0, d - 1));
      end else begin
        if (mode == 1) pg = int'($urandom_range(0, 27));
        sa = int'($urandom_range(0, d - 1));
      end
      run_round(r, pw, pg, sa, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
